ripple_carry_adder: RTL and testbench
=====================================

RIPPLE_CARRY_ADDER -- requirements
Module: ripple_carry_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width in bits; legal range 1..64.
REQ-002 clk, input, 1: single clock; all registers update on the rising edge.
REQ-003 rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-004 a, input, WIDTH: operand A, unsigned or two's complement.
REQ-005 b, input, WIDTH: operand B.
REQ-006 sum, output, WIDTH: combinational (a + b) mod 2^WIDTH, carry-in 0.
REQ-007 cin, input, 1: carry-in for the registered path only.
REQ-008 in_valid, input, 1: qualifies a/b/cin for capture.
REQ-009 sum_q, output, WIDTH: registered (a + b + cin) mod 2^WIDTH.
REQ-010 cout_q, output, 1: registered carry out of bit WIDTH-1.
REQ-011 ovf_q, output, 1: registered signed overflow.
REQ-012 out_valid, output, 1: sum_q/cout_q/ovf_q hold a fresh result this cycle.
REQ-013 Port order SHALL be a, b, sum, then clk, rst_n, cin, in_valid, sum_q, cout_q, ovf_q, out_valid; a positional 3-port connection (a, b, sum) SHALL yield a working combinational adder (remaining inputs default 0 via tie-off in the instantiating context).

Function
REQ-014 sum SHALL be purely combinational, settle within one time unit in zero-delay simulation, have no clock dependence, and be valid during reset.
REQ-015 Addition SHALL be a ripple chain: bit i full adder takes carry from bit i-1; bit 0 carry-in = 0 for sum, = cin for the registered path.
REQ-016 Per bit: s = a ^ b ^ c; c_out = (a & b) | (c & (a ^ b)).
REQ-017 Wrap-around: results above 2^WIDTH-1 SHALL truncate, e.g. 0xFFFFFFFF + 1 -> sum 0x00000000.
REQ-018 cout_q = carry out of MSB of a + b + cin (unsigned overflow).
REQ-019 ovf_q = carry into MSB XOR carry out of MSB (signed overflow).
REQ-020 On a clk edge with in_valid=1: capture sum_q, cout_q, ovf_q from the current a, b, cin; out_valid=1 next cycle (latency 1).
REQ-021 On a clk edge with in_valid=0: sum_q/cout_q/ovf_q SHALL hold; out_valid=0.
REQ-022 Back-to-back in_valid every cycle SHALL produce one result per cycle, no bubbles; no backpressure.
REQ-023 Operands SHALL not need to be held after the capturing edge.

Reset
REQ-024 rst_n=0 SHALL immediately (asynchronously) force sum_q=0, cout_q=0, ovf_q=0, out_valid=0.
REQ-025 Registers leave reset on the first rising clk after rst_n deasserts; a capture with in_valid=1 on that edge SHALL be honoured.
REQ-026 Reset mid-operation SHALL discard the pending result; no partial result appears after reset.
REQ-027 Reset SHALL not affect the combinational sum output.

Structure
REQ-028 Sub-module full_adder (a, b, cin -> s, cout), instantiated WIDTH times via generate for each chain.
REQ-029 Two independent chains: one for sum (cin=0), one for the registered path (cin=cin); chains SHALL not be shared.
REQ-030 Shared package rca_pkg holds DEFAULT_WIDTH=32 and the reset-value constants; no typedefs needed.
REQ-031 No behavioural '+' operator in the datapath; the carry chain SHALL be explicit.

Verification
REQ-032 a=0x00000005, b=0x00000007 -> sum=0x0000000C after 1 time unit.
REQ-033 a=0xFFFFFFFF, b=0x00000001, cin=0, in_valid=1 -> sum=0; next cycle sum_q=0, cout_q=1, ovf_q=0, out_valid=1.
REQ-034 a=0x7FFFFFFF, b=0x00000000, cin=1, in_valid=1 -> next cycle sum_q=0x80000000, cout_q=0, ovf_q=1.
REQ-035 10 seeded random a/b pairs, checked 1 time unit after apply -> sum equals (a+b) mod 2^32 every time, zero mismatches.
REQ-036 Capture a=3, b=4; assert rst_n=0 mid-cycle -> sum_q=0, out_valid=0 immediately, before the next clk edge.
REQ-037 in_valid held 1 for 4 cycles with a=1..4, b=10 -> sum_q = 11,12,13,14 on consecutive cycles; then in_valid=0 -> sum_q holds 14, out_valid=0.

Source files
------------

// File: rtl/rca_pkg.sv
// Shared constants for the ripple-carry adder: default width and register reset values.
package rca_pkg;

  localparam int DEFAULT_WIDTH = 32;

  // Sized at the maximum legal width; users slice down to their own WIDTH.
  localparam logic [63:0] RST_SUM   = '0;
  localparam logic        RST_COUT  = 1'b0;
  localparam logic        RST_OVF   = 1'b0;
  localparam logic        RST_VALID = 1'b0;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder, the cell that every carry chain in the adder is built from.
// Purely combinational, zero latency, no flow control.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_carry_adder.sv
// Ripple-carry adder: combinational sum (carry-in 0) plus a registered sum/carry/overflow path with carry-in.
// Registered path has 1-cycle latency and accepts a new operand pair every cycle; no backpressure.
module ripple_carry_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cin,
  input  logic             in_valid,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q,
  output logic             ovf_q,
  output logic             out_valid
);

  logic [WIDTH:0]   comb_carry;
  logic [WIDTH:0]   reg_carry;
  logic [WIDTH-1:0] sum_d;
  logic             cout_d;
  logic             ovf_d;
  logic             comb_carry_unused;

  assign comb_carry[0] = 1'b0;
  assign reg_carry[0]  = cin;

  // Two separate chains so the combinational sum never sees cin.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa_comb (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (comb_carry[i]),
      .s    (sum[i]),
      .cout (comb_carry[i+1])
    );

    full_adder u_fa_reg (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (reg_carry[i]),
      .s    (sum_d[i]),
      .cout (reg_carry[i+1])
    );
  end

  assign comb_carry_unused = comb_carry[WIDTH];
  assign cout_d = reg_carry[WIDTH];
  // Signed overflow: carry into the MSB disagrees with carry out of it.
  assign ovf_d  = reg_carry[WIDTH] ^ reg_carry[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= RST_SUM[WIDTH-1:0];
      cout_q    <= RST_COUT;
      ovf_q     <= RST_OVF;
      out_valid <= RST_VALID;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Scoreboard bench for ripple_carry_adder: random and corner operands against an arithmetic reference model.
module tb_ripple_carry_adder;

  localparam int W = 32;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         cin = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] sum;
  logic [W-1:0] sum_q;
  logic         cout_q;
  logic         ovf_q;
  logic         out_valid;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  ripple_carry_adder #(.WIDTH(W)) dut (
    .a         (a),
    .b         (b),
    .sum       (sum),
    .clk       (clk),
    .rst_n     (rst_n),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum_q     (sum_q),
    .cout_q    (cout_q),
    .ovf_q     (ovf_q),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: wide integer addition, carry from bit W, overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    exp_t        e;
    logic [W:0]  full;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    e.s  = full[W-1:0];
    e.c  = full[W];
    e.o  = (x[W-1] == y[W-1]) && (e.s[W-1] != x[W-1]);
    return e;
  endfunction

  function automatic logic [W-1:0] comb_ref(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] full;
    full = {1'b0, x} + {1'b0, y};
    return full[W-1:0];
  endfunction

  task automatic apply(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                       input logic v, input bit push);
    a        = x;
    b        = y;
    cin      = c;
    in_valid = v;
    if (v && push) sb.push_back(model(x, y, c));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_result: got sum_q=0x%0h with out_valid=1, expected no result", sum_q);
      end else begin
        e = sb.pop_front();
        chk("sb_sum_q", 64'(sum_q), 64'(e.s));
        chk("sb_cout_q", 64'(cout_q), 64'(e.c));
        chk("sb_ovf_q", 64'(ovf_q), 64'(e.o));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] x, y;
    logic         c;

    void'($urandom(32'h5EED_0042));
    rst_n = 1'b0;
    #1;
    chk("rst_sum_q", 64'(sum_q), 64'd0);
    chk("rst_cout_q", 64'(cout_q), 64'd0);
    chk("rst_ovf_q", 64'(ovf_q), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);

    apply(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b0, 0);
    #1;
    chk("comb_5_7_in_reset", 64'(sum), 64'h0000_000C);

    // Capture armed while still in reset must be taken on the first edge after release.
    apply(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1, 1);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    apply(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1);
    #1;
    chk("comb_wrap", 64'(sum), 64'd0);
    step();
    apply(32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 1);
    #1;
    chk("comb_7fff_0", 64'(sum), 64'h7FFF_FFFF);
    step();
    apply(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1);
    step();
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1);

    for (int i = 0; i < 10; i++) begin
      step();
      chk("b2b_out_valid", 64'(out_valid), 64'd1);
      x = $urandom;
      y = $urandom;
      c = 1'($urandom_range(0, 1));
      apply(x, y, c, 1'b1, 1);
      #1;
      chk("comb_random", 64'(sum), 64'(comb_ref(x, y)));
    end

    for (int i = 1; i <= 4; i++) begin
      step();
      apply(W'(i), 32'd10, 1'b0, 1'b1, 1);
    end
    step();
    apply(32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b1, 1'b0, 0);
    step();
    chk("hold_sum_q", 64'(sum_q), 64'd14);
    chk("hold_out_valid", 64'(out_valid), 64'd0);
    step();
    chk("hold_sum_q_2", 64'(sum_q), 64'd14);

    apply(32'd3, 32'd4, 1'b0, 1'b1, 0);
    step();
    apply(32'd3, 32'd4, 1'b0, 1'b0, 0);
    chk("pre_rst_sum_q", 64'(sum_q), 64'd7);
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_sum_q", 64'(sum_q), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_cout_q", 64'(cout_q), 64'd0);
    chk("midrst_comb_sum", 64'(sum), 64'd7);
    step();
    chk("rst_held_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);
    chk("post_rst_sum_q", 64'(sum_q), 64'd0);

    repeat (3) step();
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
